// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   NOP               : instruction word used for pipeline bubbles
//   DEFAULT_RESET_PC  : first fetch address after reset unless overridden
//   fetch_state_t     : fetch-stage FSM encoding
//   word_align()      : clears the byte-offset bits of an address
package mips_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction register that parks a fetched word while decode is
// stalled.
//   clock, reset_n : clock and synchronous active-low reset
//   load           : capture load_data (ignored when clear is high)
//   clear          : empty the buffer
//   load_data      : instruction word to capture
//   data           : buffered instruction (NOP when empty)
//   valid          : buffer holds a word
module fetch_hold_buf
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_data,
    output logic [31:0] data,
    output logic        valid
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data  <= NOP;
            valid <= 1'b0;
        end else if (clear) begin
            data  <= NOP;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from instruction
// memory over a req/ack handshake and drives the IF/ID pipeline register.
//   clock, reset_n      : clock and synchronous active-low reset
//   stall_i             : decode stalled, IF/ID must hold
//   redirect_i          : taken branch/jump, flushes IF/ID
//   redirect_pc_i       : redirect target (low two bits ignored)
//   imem_req_o/addr_o   : instruction memory request and word address
//   imem_ack_i/rdata_i  : read data valid / instruction word
//   ifid_valid_o        : IF/ID holds a real instruction
//   ifid_instr_o        : IF/ID instruction (NOP when invalid)
//   ifid_pc4_o          : PC+4 of the IF/ID instruction
//   fetch_count_o       : instructions delivered into IF/ID (wraps)
//
// state   | meaning
// IDLE    | one cycle after reset, no request
// FETCH   | requesting req_addr, delivering to IF/ID on ack
// DISCARD | redirected mid-request; wait out the old ack and drop it
// HOLD    | word arrived during a stall, parked in the hold buffer
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic [31:0]  req_addr, req_addr_d;
    logic [31:0]  pc_plus4, target;
    logic         ifid_valid_d;
    logic [31:0]  ifid_instr_d, ifid_pc4_d, fetch_count_d;
    logic         hold_load, hold_clear, hold_valid;
    logic [31:0]  hold_data;

    assign target      = word_align(redirect_pc_i);
    assign pc_plus4    = pc + 32'd4;
    assign imem_addr_o = req_addr;

    fetch_hold_buf u_hold_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_data (imem_rdata_i),
        .data      (hold_data),
        .valid     (hold_valid)
    );

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        ifid_valid_d  = ifid_valid_o;
        ifid_instr_d  = ifid_instr_o;
        ifid_pc4_d    = ifid_pc4_o;
        fetch_count_d = fetch_count_o;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;
        imem_req_o    = 1'b0;

        case (state)
            IDLE: begin
                if (redirect_i) begin
                    pc_d = target;
                end
                state_d = FETCH;
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    pc_d         = target;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                    ifid_pc4_d   = 32'h0;
                    // Without an ack the old request is still outstanding and
                    // must complete before the target can be requested.
                    state_d      = imem_ack_i ? FETCH : DISCARD;
                end else if (imem_ack_i) begin
                    if (stall_i) begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        ifid_valid_d  = 1'b1;
                        ifid_instr_d  = imem_rdata_i;
                        ifid_pc4_d    = pc_plus4;
                        pc_d          = pc_plus4;
                        fetch_count_d = fetch_count_o + 32'd1;
                    end
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                    ifid_pc4_d   = 32'h0;
                end
            end
            DISCARD: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    pc_d = target;
                end
                if (imem_ack_i) begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    hold_clear   = 1'b1;
                    pc_d         = target;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                    ifid_pc4_d   = 32'h0;
                    state_d      = FETCH;
                end else if (!stall_i) begin
                    hold_clear    = 1'b1;
                    ifid_valid_d  = hold_valid;
                    ifid_instr_d  = hold_data;
                    ifid_pc4_d    = pc_plus4;
                    pc_d          = pc_plus4;
                    fetch_count_d = fetch_count_o + 32'd1;
                    state_d       = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every transition into (or within) FETCH latches the next PC as the
        // request address; in other states the outstanding address is kept.
        req_addr_d = (state_d == FETCH) ? pc_d : req_addr;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            ifid_valid_o  <= 1'b0;
            ifid_instr_o  <= NOP;
            ifid_pc4_o    <= 32'h0;
            fetch_count_o <= 32'h0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            req_addr      <= req_addr_d;
            ifid_valid_o  <= ifid_valid_d;
            ifid_instr_o  <= ifid_instr_d;
            ifid_pc4_o    <= ifid_pc4_d;
            fetch_count_o <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] fetch_count_o;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .fetch_count_o (fetch_count_o)
    );

    int checks   = 0;
    int failures = 0;

    // memory model
    int          mem_lat  = 0;
    int          wait_cnt = 0;
    logic [31:0] data_key = 32'h0;
    logic        last_req, last_ack;
    logic [31:0] last_addr;

    // scoreboard
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;
    sb_t sb_q[$];
    bit  sb_en      = 1'b0;
    bit  disc       = 1'b0;
    int  deliveries = 0;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tg;
        logic        v;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        req;
        logic [31:0] addr;
        logic [31:0] cnt;
    } vec_t;
    vec_t vecs[18];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check1 ({tag, "_req"},   imem_req_o,    1'b0);
        check32({tag, "_addr"},  imem_addr_o,   32'h0);
        check1 ({tag, "_valid"}, ifid_valid_o,  1'b0);
        check32({tag, "_instr"}, ifid_instr_o,  32'h0);
        check32({tag, "_pc4"},   ifid_pc4_o,    32'h0);
        check32({tag, "_count"}, fetch_count_o, 32'h0);
    endtask

    // One clock cycle: drive inputs at negedge, memory answers the current
    // request, sample outputs 1 time unit after the rising edge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] tg, input logic rst);
        logic pushed;
        sb_t  e;
        @(negedge clock);
        reset_n       = !rst;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tg;
        last_req      = imem_req_o;
        last_addr     = imem_addr_o;
        last_ack      = imem_req_o && (wait_cnt >= mem_lat);
        imem_ack_i    = last_ack;
        imem_rdata_i  = last_ack ? (imem_addr_o ^ data_key) : 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        if (rst || !last_req || last_ack) wait_cnt = 0;
        else wait_cnt++;
        if (rst) begin
            sb_q.delete();
            disc       = 1'b0;
            deliveries = 0;
            return;
        end
        if (sb_en) begin
            pushed = 1'b0;
            if (last_ack) begin
                if (rd || disc) begin
                    disc = 1'b0;
                end else begin
                    e.instr = last_addr ^ data_key;
                    e.pc4   = last_addr + 32'd4;
                    sb_q.push_back(e);
                    pushed = 1'b1;
                end
            end else if (last_req && rd) begin
                disc = 1'b1;
            end
            check1("ifid_latency", ifid_valid_o, pushed);
            if (last_req && !last_ack) begin
                check1 ("req_held",    imem_req_o,  1'b1);
                check32("addr_stable", imem_addr_o, last_addr);
            end
            if (ifid_valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%h required=none", ifid_instr_o);
                end else begin
                    e = sb_q.pop_front();
                    check32("sb_instr", ifid_instr_o, e.instr);
                    check32("sb_pc4",   ifid_pc4_o,   e.pc4);
                    deliveries++;
                end
            end else begin
                check32("bubble", ifid_instr_o | ifid_pc4_o, 32'h0);
            end
            check32("fetch_count", fetch_count_o, 32'(deliveries));
        end
    endtask

    task automatic do_reset(input int lat, input logic [31:0] key, input bit sb);
        mem_lat  = lat;
        data_key = key;
        sb_en    = 1'b0;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        sb_en    = sb;
    endtask

    initial begin
        int  prev_del;
        bit  bad8;

        reset_n       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'h0;

        // ---------------- reset + zero-wait streaming ----------------
        do_reset(0, 32'h0, 1'b1);
        check_reset_values("rst0");
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        check1("first_cycle_no_req", last_req, 1'b0);
        check1("second_cycle_req",   imem_req_o, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        check32("zw_third_pc4",   ifid_pc4_o,    32'hC);
        check32("zw_third_instr", ifid_instr_o,  32'h8);
        check32("zw_count3",      fetch_count_o, 32'd3);
        for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        check32("zw_count20", fetch_count_o, 32'd20);

        // ---------------- 2-cycle ack latency ----------------
        do_reset(2, K, 1'b1);
        prev_del = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            if (ifid_valid_o) begin
                if (prev_del >= 0) check32("lat2_gap", 32'(i - prev_del), 32'd3);
                prev_del = i;
            end
        end
        check32("lat2_count", fetch_count_o, 32'd9);

        // ---------------- table: stalls, HOLD, redirects, wrap ----------------
        vecs[0]  = '{0, 0, 32'h0,         0, 32'h0,             32'h0,   1, 32'h0,         32'd0};
        vecs[1]  = '{0, 0, 32'h0,         1, K ^ 32'h0,         32'h4,   1, 32'h4,         32'd1};
        vecs[2]  = '{0, 0, 32'h0,         1, K ^ 32'h4,         32'h8,   1, 32'h8,         32'd2};
        vecs[3]  = '{0, 0, 32'h0,         1, K ^ 32'h8,         32'hC,   1, 32'hC,         32'd3};
        vecs[4]  = '{0, 0, 32'h0,         1, K ^ 32'hC,         32'h10,  1, 32'h10,        32'd4};
        vecs[5]  = '{1, 0, 32'h0,         1, K ^ 32'hC,         32'h10,  0, 32'h10,        32'd4};
        vecs[6]  = '{1, 0, 32'h0,         1, K ^ 32'hC,         32'h10,  0, 32'h10,        32'd4};
        vecs[7]  = '{1, 0, 32'h0,         1, K ^ 32'hC,         32'h10,  0, 32'h10,        32'd4};
        vecs[8]  = '{0, 0, 32'h0,         1, K ^ 32'h10,        32'h14,  1, 32'h14,        32'd5};
        vecs[9]  = '{0, 1, 32'h43,        0, 32'h0,             32'h0,   1, 32'h40,        32'd5};
        vecs[10] = '{0, 0, 32'h0,         1, K ^ 32'h40,        32'h44,  1, 32'h44,        32'd6};
        vecs[11] = '{1, 0, 32'h0,         1, K ^ 32'h40,        32'h44,  0, 32'h44,        32'd6};
        vecs[12] = '{1, 1, 32'h103,       0, 32'h0,             32'h0,   1, 32'h100,       32'd6};
        vecs[13] = '{0, 0, 32'h0,         1, K ^ 32'h100,       32'h104, 1, 32'h104,       32'd7};
        vecs[14] = '{0, 1, 32'hFFFF_FFFC, 0, 32'h0,             32'h0,   1, 32'hFFFF_FFFC, 32'd7};
        vecs[15] = '{0, 0, 32'h0,         1, K ^ 32'hFFFF_FFFC, 32'h0,   1, 32'h0,         32'd8};
        vecs[16] = '{1, 0, 32'h0,         1, K ^ 32'hFFFF_FFFC, 32'h0,   0, 32'h0,         32'd8};
        vecs[17] = '{0, 0, 32'h0,         1, K ^ 32'h0,         32'h4,   1, 32'h4,         32'd9};

        do_reset(0, K, 1'b0);
        foreach (vecs[i]) begin
            tick(vecs[i].st, vecs[i].rd, vecs[i].tg, 1'b0);
            check1 ($sformatf("vec%0d_valid", i), ifid_valid_o,  vecs[i].v);
            check32($sformatf("vec%0d_instr", i), ifid_instr_o,  vecs[i].ins);
            check32($sformatf("vec%0d_pc4",   i), ifid_pc4_o,    vecs[i].p4);
            check1 ($sformatf("vec%0d_req",   i), imem_req_o,    vecs[i].req);
            check32($sformatf("vec%0d_addr",  i), imem_addr_o,   vecs[i].addr);
            check32($sformatf("vec%0d_count", i), fetch_count_o, vecs[i].cnt);
        end

        // ---------------- redirect while a request waits (DISCARD) ----------------
        do_reset(2, K, 1'b1);
        bad8 = 1'b0;
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        check32("disc_pre_addr", imem_addr_o, 32'h8);
        tick(1'b0, 1'b1, 32'h40, 1'b0);
        if (ifid_instr_o == (K ^ 32'h8)) bad8 = 1'b1;
        check32("disc_hold_addr", imem_addr_o, 32'h8);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            if (ifid_instr_o == (K ^ 32'h8)) bad8 = 1'b1;
        end
        check1 ("disc_next_req",  imem_req_o,  1'b1);
        check32("disc_next_addr", imem_addr_o, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            if (ifid_instr_o == (K ^ 32'h8)) bad8 = 1'b1;
        end
        check1 ("disc_no_word8",   bad8,          1'b0);
        check32("disc_target_pc4", ifid_pc4_o,    32'h44);
        check32("disc_count",      fetch_count_o, 32'd3);

        // ---------------- reset mid-DISCARD with ack in flight ----------------
        tick(1'b0, 1'b1, 32'h80, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check_reset_values("rst_disc");
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        check1 ("rst_restart_req",  imem_req_o,  1'b1);
        check32("rst_restart_addr", imem_addr_o, 32'h0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        check32("rst_restart_instr", ifid_instr_o, K ^ 32'h0);
        check32("rst_restart_pc4",   ifid_pc4_o,   32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
